// File: rtl/prog_ctr_fetch_pkg.sv
// ============================================================================
// Module   : prog_ctr_fetch_pkg
// Brief    : Shared definitions for the program-counter / fetch stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package prog_ctr_fetch_pkg;

    localparam int PC_W = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/prog_ctr_fetch.sv
// ============================================================================
// Module   : prog_ctr_fetch
// Brief    : PC register, branch resolution, start/run/done handshake and
//            saturating run-cycle counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module prog_ctr_fetch
    import prog_ctr_fetch_pkg::*;
#(
    parameter int T          = PC_W,
    parameter int W          = 8,
    parameter int START_ADDR = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             done_in,
    input  logic             branch_ez,
    input  logic             branch_nz,
    input  logic             branch_always,
    input  logic             zero_flag,
    input  logic [W-1:0]     target,
    output logic [T-1:0]     prog_ctr,
    output logic [T-1:0]     prog_ctr_p1,
    output logic             running,
    output logic             done,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [T-1:0] c_start_addr = T'(START_ADDR);

    fetch_state_t     r_state;
    logic [T-1:0]     r_prog_ctr;
    logic             r_running;
    logic             r_done;
    logic [CNT_W-1:0] r_cycle_count;

    logic             w_taken;
    logic [T-1:0]     w_branch_pc;
    logic [T-1:0]     w_next_pc;

    assign w_taken = branch_always
                   | (branch_ez &  zero_flag)
                   | (branch_nz & ~zero_flag);

    // A taken branch only replaces the low W bits, keeping the current page.
    generate
        if (T > W) begin : g_paged
            assign w_branch_pc = {r_prog_ctr[T-1:W], target};
        end else begin : g_flat
            assign w_branch_pc = target[T-1:0];
        end
    endgenerate

    always_comb begin
        w_next_pc = r_prog_ctr + T'(1);
        if (w_taken) begin
            w_next_pc = w_branch_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_prog_ctr    <= c_start_addr;
            r_running     <= 1'b0;
            r_done        <= 1'b0;
            r_cycle_count <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state       <= RUN;
                        r_prog_ctr    <= c_start_addr;
                        r_running     <= 1'b1;
                        r_done        <= 1'b0;
                        r_cycle_count <= '0;
                    end
                end
                RUN: begin
                    if (r_cycle_count != {CNT_W{1'b1}}) begin
                        r_cycle_count <= r_cycle_count + CNT_W'(1);
                    end
                    // DNE takes priority over any branch and parks the PC.
                    if (done_in) begin
                        r_state   <= DONE;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                    end else begin
                        r_prog_ctr <= w_next_pc;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_running <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    assign prog_ctr    = r_prog_ctr;
    assign prog_ctr_p1 = r_prog_ctr + T'(1);
    assign running     = r_running;
    assign done        = r_done;
    assign cycle_count = r_cycle_count;

endmodule

`default_nettype wire

// File: tb/tb_prog_ctr_fetch.sv
// ============================================================================
// Module   : tb_prog_ctr_fetch
// Brief    : Directed self-checking bench for prog_ctr_fetch.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_prog_ctr_fetch;

    localparam int c_t     = 10;
    localparam int c_w     = 8;
    localparam int c_start = 0;
    localparam int c_cnt_w = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             done_in;
    logic             branch_ez;
    logic             branch_nz;
    logic             branch_always;
    logic             zero_flag;
    logic [c_w-1:0]   target;
    logic [c_t-1:0]   prog_ctr;
    logic [c_t-1:0]   prog_ctr_p1;
    logic             running;
    logic             done;
    logic [c_cnt_w-1:0] cycle_count;

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    // Behavioural model: mode 0=idle, 1=run, 2=done.
    int m_mode = 0;
    int m_pc   = c_start;
    int m_cnt  = 0;

    prog_ctr_fetch #(
        .T          (c_t),
        .W          (c_w),
        .START_ADDR (c_start),
        .CNT_W      (c_cnt_w)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .done_in       (done_in),
        .branch_ez     (branch_ez),
        .branch_nz     (branch_nz),
        .branch_always (branch_always),
        .zero_flag     (zero_flag),
        .target        (target),
        .prog_ctr      (prog_ctr),
        .prog_ctr_p1   (prog_ctr_p1),
        .running       (running),
        .done          (done),
        .cycle_count   (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode = 0;
            m_pc   = c_start;
            m_cnt  = 0;
        end else if (m_mode != 1) begin
            if (start) begin
                m_mode = 1;
                m_pc   = c_start;
                m_cnt  = 0;
            end
        end else begin
            if (m_cnt < (1 << c_cnt_w) - 1) m_cnt = m_cnt + 1;
            if (done_in)
                m_mode = 2;
            else if (branch_always || (branch_ez && zero_flag) || (branch_nz && !zero_flag))
                m_pc = (m_pc / 256) * 256 + int'(target);
            else
                m_pc = (m_pc + 1) % (1 << c_t);
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("model_pc",      int'(prog_ctr),    m_pc);
            chk("model_pc_p1",   int'(prog_ctr_p1), (m_pc + 1) % (1 << c_t));
            chk("model_running", int'(running),     int'(m_mode == 1));
            chk("model_done",    int'(done),        int'(m_mode == 2));
            chk("model_count",   int'(cycle_count), m_cnt);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobes(input logic al, input logic ez, input logic nz,
                           input logic z, input logic [c_w-1:0] tg);
        branch_always = al;
        branch_ez     = ez;
        branch_nz     = nz;
        zero_flag     = z;
        target        = tg;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        done_in = 1'b0;
        strobes(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step();
        checking = 1'b1;
        step();
        rst_n = 1'b1;
        chk("rst_pc",      int'(prog_ctr),    0);
        chk("rst_pc_p1",   int'(prog_ctr_p1), 1);
        chk("rst_running", int'(running),     0);
        chk("rst_done",    int'(done),        0);
        chk("rst_count",   int'(cycle_count), 0);

        // Launch and free-run
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_pc", int'(prog_ctr), 0);
        chk("start_running", int'(running), 1);
        repeat (5) step();
        chk("run5_pc", int'(prog_ctr), 5);
        chk("run5_count", int'(cycle_count), 5);
        repeat (251) step();
        chk("page1_pc", int'(prog_ctr), 'h100);

        // Unconditional branches stay in page 1
        strobes(1'b1, 1'b0, 1'b0, 1'b0, 8'h05);
        step();
        chk("jmp_pc", int'(prog_ctr), 'h105);
        target = 8'h20;
        chk("jmp_p1", int'(prog_ctr_p1), 'h106);
        step();
        strobes(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("jmp2_pc", int'(prog_ctr), 'h120);

        // Wrap at top of address space
        repeat ('h3FF - 'h120) step();
        chk("top_pc", int'(prog_ctr), 'h3FF);
        step();
        chk("wrap_pc", int'(prog_ctr), 0);

        // Conditional branches
        strobes(1'b1, 1'b0, 1'b0, 1'b0, 8'h10);
        step();
        chk("to10_pc", int'(prog_ctr), 'h010);
        strobes(1'b0, 1'b1, 1'b0, 1'b0, 8'h40);
        step();
        chk("jez_nt_pc", int'(prog_ctr), 'h011);
        zero_flag = 1'b1;
        step();
        chk("jez_t_pc", int'(prog_ctr), 'h040);
        strobes(1'b0, 1'b0, 1'b1, 1'b1, 8'h80);
        step();
        chk("jnz_nt_pc", int'(prog_ctr), 'h041);
        zero_flag = 1'b0;
        step();
        chk("jnz_t_pc", int'(prog_ctr), 'h080);
        strobes(1'b0, 1'b1, 1'b1, 1'b1, 8'h33);
        step();
        chk("multi_pc", int'(prog_ctr), 'h033);

        // Done beats branch
        strobes(1'b1, 1'b0, 1'b0, 1'b0, 8'h77);
        done_in = 1'b1;
        step();
        done_in = 1'b0;
        chk("dne_pc", int'(prog_ctr), 'h033);
        chk("dne_done", int'(done), 1);
        chk("dne_running", int'(running), 0);
        target = 8'h55;
        done_in = 1'b1;
        repeat (3) step();
        done_in = 1'b0;
        chk("dne_hold_pc", int'(prog_ctr), 'h033);

        // Restart from DONE
        strobes(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_pc", int'(prog_ctr), 0);
        chk("restart_count", int'(cycle_count), 0);
        chk("restart_running", int'(running), 1);
        chk("restart_done", int'(done), 0);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("start_ignored_pc", int'(prog_ctr), 3);

        // Reset mid-run
        strobes(1'b1, 1'b0, 1'b0, 1'b0, 8'hA7);
        step();
        chk("a7_pc", int'(prog_ctr), 'h0A7);
        rst_n = 1'b0;
        start = 1'b1;
        done_in = 1'b1;
        step();
        rst_n = 1'b1;
        start = 1'b0;
        done_in = 1'b0;
        strobes(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("midrst_pc", int'(prog_ctr), 0);
        chk("midrst_running", int'(running), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_count", int'(cycle_count), 0);
        repeat (3) step();
        chk("idle_hold_pc", int'(prog_ctr), 0);

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
